// File: rtl/recibir_respuesta_pkg.sv
// rtl/recibir_respuesta_pkg.sv - shared constants, FSM encoding and helpers for the UART response receiver
package recibir_respuesta_pkg;

  localparam logic [7:0] CH_O  = 8'h4F;
  localparam logic [7:0] CH_K  = 8'h4B;
  localparam logic [7:0] CH_E  = 8'h45;
  localparam logic [7:0] CH_R  = 8'h52;
  localparam logic [7:0] CH_CR = 8'h0D;
  localparam logic [7:0] CH_LF = 8'h0A;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BRK   = 3'd4
  } rx_state_e;

  // Clock cycles per oversample tick, truncated.
  function automatic int unsigned calc_div(input int unsigned clk_freq,
                                           input int unsigned baud,
                                           input int unsigned oversample);
    return clk_freq / (baud * oversample);
  endfunction

  // Expected character at each position of "OK\r\n".
  function automatic logic [7:0] ok_char(input logic [1:0] idx);
    case (idx)
      2'd0:    return CH_O;
      2'd1:    return CH_K;
      2'd2:    return CH_CR;
      default: return CH_LF;
    endcase
  endfunction

  // Expected character at each position of "ERROR\r\n".
  function automatic logic [7:0] err_char(input logic [2:0] idx);
    case (idx)
      3'd0:    return CH_E;
      3'd1:    return CH_R;
      3'd2:    return CH_R;
      3'd3:    return CH_O;
      3'd4:    return CH_R;
      3'd5:    return CH_CR;
      default: return CH_LF;
    endcase
  endfunction

endpackage

// File: rtl/recibir_respuesta_uart_rx_byte.sv
// rtl/recibir_respuesta_uart_rx_byte.sv - oversampling 8N1 byte deframer with break handling
module uart_rx_byte
  import recibir_respuesta_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 50000000,
  parameter int unsigned BAUD       = 9600,
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       rx_i,
  output logic [7:0] data_out_o,
  output logic       data_valid_o,
  output logic       frame_err_o,
  output logic       busy_o
);

  localparam int unsigned DIV    = calc_div(CLK_FREQ, BAUD, OVERSAMPLE);
  localparam int unsigned CNT_W  = (DIV > 2) ? $clog2(DIV) : 1;
  localparam int unsigned SAMP_W = (OVERSAMPLE > 2) ? $clog2(OVERSAMPLE) : 1;

  localparam logic [CNT_W-1:0]  TICK_LAST = CNT_W'(DIV - 1);
  localparam logic [SAMP_W-1:0] HALF_LAST = SAMP_W'(OVERSAMPLE / 2 - 1);
  localparam logic [SAMP_W-1:0] FULL_LAST = SAMP_W'(OVERSAMPLE - 1);

  logic              rx_meta_q;
  logic              rx_s_q;
  logic [1:0]        fill_q;
  logic              armed_q;
  logic [CNT_W-1:0]  tick_cnt_q;
  logic [CNT_W-1:0]  tick_cnt_d;
  logic              tick;
  logic [SAMP_W-1:0] samp_cnt_q;
  logic [2:0]        bit_cnt_q;
  logic [7:0]        shift_q;
  logic [7:0]        data_q;
  logic              valid_q;
  logic              ferr_q;
  logic              busy_q;
  rx_state_e         state_q;

  assign tick         = (tick_cnt_q == TICK_LAST);
  assign data_out_o   = data_q;
  assign data_valid_o = valid_q;
  assign frame_err_o  = ferr_q;
  assign busy_o       = busy_q;

  // Two-flop synchronizer; arming waits until the pipeline holds real pin
  // samples and the line has been seen high, so a held-low line after reset
  // never starts a frame.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      fill_q    <= 2'b00;
      armed_q   <= 1'b0;
    end else begin
      rx_meta_q <= rx_i;
      rx_s_q    <= rx_meta_q;
      fill_q    <= {fill_q[0], 1'b1};
      if (fill_q[1] && rx_s_q) begin
        armed_q <= 1'b1;
      end
    end
  end

  // Tick counter next state: held at zero in IDLE so START always begins at a clean phase.
  always_comb begin
    tick_cnt_d = tick_cnt_q;
    if (state_q == IDLE) begin
      tick_cnt_d = '0;
    end else if (tick) begin
      tick_cnt_d = '0;
    end else begin
      tick_cnt_d = tick_cnt_q + 1'b1;
    end
  end

  // Deframing FSM with registered strobes and busy flag.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      tick_cnt_q <= '0;
      samp_cnt_q <= '0;
      bit_cnt_q  <= 3'd0;
      shift_q    <= 8'h00;
      data_q     <= 8'h00;
      valid_q    <= 1'b0;
      ferr_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      tick_cnt_q <= tick_cnt_d;
      valid_q    <= 1'b0;
      ferr_q     <= 1'b0;
      case (state_q)
        IDLE: begin
          if (armed_q && !rx_s_q) begin
            state_q    <= START;
            samp_cnt_q <= '0;
            busy_q     <= 1'b1;
          end
        end
        START: begin
          if (tick) begin
            if (samp_cnt_q == HALF_LAST) begin
              samp_cnt_q <= '0;
              if (rx_s_q) begin
                state_q <= IDLE;
                busy_q  <= 1'b0;
              end else begin
                state_q   <= DATA;
                bit_cnt_q <= 3'd0;
              end
            end else begin
              samp_cnt_q <= samp_cnt_q + 1'b1;
            end
          end
        end
        DATA: begin
          if (tick) begin
            if (samp_cnt_q == FULL_LAST) begin
              samp_cnt_q <= '0;
              shift_q    <= {rx_s_q, shift_q[7:1]};
              if (bit_cnt_q == 3'd7) begin
                state_q <= STOP;
              end else begin
                bit_cnt_q <= bit_cnt_q + 3'd1;
              end
            end else begin
              samp_cnt_q <= samp_cnt_q + 1'b1;
            end
          end
        end
        STOP: begin
          if (tick) begin
            if (samp_cnt_q == FULL_LAST) begin
              samp_cnt_q <= '0;
              if (rx_s_q) begin
                data_q  <= shift_q;
                valid_q <= 1'b1;
                busy_q  <= 1'b0;
                state_q <= IDLE;
              end else begin
                ferr_q  <= 1'b1;
                state_q <= BRK;
              end
            end else begin
              samp_cnt_q <= samp_cnt_q + 1'b1;
            end
          end
        end
        BRK: begin
          if (rx_s_q) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/recibir_respuesta.sv
// rtl/recibir_respuesta.sv - UART receive path with "OK\r\n" / "ERROR\r\n" response detection
module recibir_respuesta
  import recibir_respuesta_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 50000000,
  parameter int unsigned BAUD       = 9600,
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       rx_i,
  output logic [7:0] data_out_o,
  output logic       data_valid_o,
  output logic       frame_err_o,
  output logic       busy_o,
  output logic       resp_ok_o,
  output logic       resp_err_o
);

  logic [7:0] byte_data;
  logic       byte_valid;
  logic       byte_ferr;

  logic [1:0] ok_idx_q;
  logic [1:0] ok_idx_d;
  logic [2:0] err_idx_q;
  logic [2:0] err_idx_d;
  logic       resp_ok_q;
  logic       resp_ok_d;
  logic       resp_err_q;
  logic       resp_err_d;

  uart_rx_byte #(
    .CLK_FREQ  (CLK_FREQ),
    .BAUD      (BAUD),
    .OVERSAMPLE(OVERSAMPLE)
  ) u_rx_byte (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .rx_i        (rx_i),
    .data_out_o  (byte_data),
    .data_valid_o(byte_valid),
    .frame_err_o (byte_ferr),
    .busy_o      (busy_o)
  );

  assign data_out_o   = byte_data;
  assign data_valid_o = byte_valid;
  assign frame_err_o  = byte_ferr;
  assign resp_ok_o    = resp_ok_q;
  assign resp_err_o   = resp_err_q;

  // Response matchers: each index tracks how much of its string has been seen;
  // on a miss it restarts at 1 only if the byte opens the string again.
  always_comb begin
    ok_idx_d   = ok_idx_q;
    err_idx_d  = err_idx_q;
    resp_ok_d  = 1'b0;
    resp_err_d = 1'b0;
    if (byte_ferr) begin
      ok_idx_d  = 2'd0;
      err_idx_d = 3'd0;
    end else if (byte_valid) begin
      if (byte_data == ok_char(ok_idx_q)) begin
        if (ok_idx_q == 2'd3) begin
          ok_idx_d  = 2'd0;
          resp_ok_d = 1'b1;
        end else begin
          ok_idx_d = ok_idx_q + 2'd1;
        end
      end else begin
        ok_idx_d = (byte_data == CH_O) ? 2'd1 : 2'd0;
      end
      if (byte_data == err_char(err_idx_q)) begin
        if (err_idx_q == 3'd6) begin
          err_idx_d  = 3'd0;
          resp_err_d = 1'b1;
        end else begin
          err_idx_d = err_idx_q + 3'd1;
        end
      end else begin
        err_idx_d = (byte_data == CH_E) ? 3'd1 : 3'd0;
      end
    end
  end

  // Matcher state and one-cycle response pulses.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ok_idx_q   <= 2'd0;
      err_idx_q  <= 3'd0;
      resp_ok_q  <= 1'b0;
      resp_err_q <= 1'b0;
    end else begin
      ok_idx_q   <= ok_idx_d;
      err_idx_q  <= err_idx_d;
      resp_ok_q  <= resp_ok_d;
      resp_err_q <= resp_err_d;
    end
  end

endmodule

// File: tb/tb_recibir_respuesta.sv
// tb/tb_recibir_respuesta.sv - scoreboard bench for the UART response receiver
module tb_recibir_respuesta;

  localparam int BIT_CLKS = 160;
  localparam int DV_LAT   = 1523;
  localparam int EV_DV = 0;
  localparam int EV_FE = 1;
  localparam int EV_OK = 2;
  localparam int EV_ER = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic [7:0] data_out;
  logic       data_valid;
  logic       frame_err;
  logic       busy;
  logic       resp_ok;
  logic       resp_err;

  typedef struct {
    int         kind;
    logic [7:0] data;
    int         start;
  } ev_t;

  ev_t        exp_q[$];
  logic [7:0] hist[$];
  logic [7:0] last_good = 8'h00;
  int         cyc = 0;
  int         last_dv_cyc = -100;
  int         checks = 0;
  int         errors = 0;

  recibir_respuesta #(
    .CLK_FREQ  (1600000),
    .BAUD      (10000),
    .OVERSAMPLE(16)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .rx_i        (rx),
    .data_out_o  (data_out),
    .data_valid_o(data_valid),
    .frame_err_o (frame_err),
    .busy_o      (busy),
    .resp_ok_o   (resp_ok),
    .resp_err_o  (resp_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic bit suffix_is(input string p);
    int n;
    n = p.len();
    if (hist.size() < n) return 1'b0;
    for (int i = 0; i < n; i++) begin
      if (hist[hist.size() - n + i] != 8'(p[i])) return 1'b0;
    end
    return 1'b1;
  endfunction

  // Reference model: a good byte is reported, then the received text since
  // the last clear is tested for ending in one of the modem responses.
  task automatic model_byte(input logic [7:0] b, input int t0);
    ev_t e;
    e.kind = EV_DV; e.data = b; e.start = t0;
    exp_q.push_back(e);
    last_good = b;
    hist.push_back(b);
    if (suffix_is("OK\r\n")) begin
      e.kind = EV_OK; e.data = 8'h00;
      exp_q.push_back(e);
    end
    if (suffix_is("ERROR\r\n")) begin
      e.kind = EV_ER; e.data = 8'h00;
      exp_q.push_back(e);
    end
  endtask

  task automatic model_ferr(input int t0);
    ev_t e;
    e.kind = EV_FE; e.data = last_good; e.start = t0;
    exp_q.push_back(e);
    hist.delete();
  endtask

  task automatic drive_bit(input logic v, input int n);
    #1 rx = v;
    repeat (n) @(posedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_v);
    int t0;
    #1 t0 = cyc;
    if (stop_v) model_byte(b, t0);
    else model_ferr(t0);
    rx = 1'b0;
    repeat (BIT_CLKS) @(posedge clk);
    for (int i = 0; i < 8; i++) drive_bit(b[i], BIT_CLKS);
    drive_bit(stop_v, BIT_CLKS);
  endtask

  task automatic send_string(input string s);
    for (int i = 0; i < s.len(); i++) send_frame(8'(s[i]), 1'b1);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_data_out"}, data_out, 8'h00);
    chk({tag, "_data_valid"}, data_valid, 1'b0);
    chk({tag, "_frame_err"}, frame_err, 1'b0);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_resp_ok"}, resp_ok, 1'b0);
    chk({tag, "_resp_err"}, resp_err, 1'b0);
  endtask

  task automatic observe(input int kind);
    ev_t e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_strobe actual=kind%0d required=none cycle=%0d", kind, cyc);
      return;
    end
    e = exp_q.pop_front();
    chk("event_kind", kind, e.kind);
    if (e.kind != kind) return;
    case (kind)
      EV_DV: begin
        chk("dv_data", data_out, e.data);
        chk("dv_busy_low", busy, 1'b0);
        chk("dv_latency", cyc - e.start, DV_LAT);
        last_dv_cyc = cyc;
      end
      EV_FE: chk("ferr_data_hold", data_out, e.data);
      default: chk("resp_latency", cyc - last_dv_cyc, 1);
    endcase
  endtask

  // Monitor: every strobe the DUT presents is matched against the scoreboard.
  always @(negedge clk) begin
    if (rst_n) begin
      if (data_valid) observe(EV_DV);
      if (frame_err) observe(EV_FE);
      if (resp_ok) observe(EV_OK);
      if (resp_err) observe(EV_ER);
    end
  end

  initial begin
    logic [7:0] rb;
    int         sel;
    int         gap;

    // Reset state
    repeat (3) @(posedge clk);
    #1 chk_all_zero("reset");
    rst_n = 1'b1;
    repeat (20) @(posedge clk);

    // Single clean frame
    send_frame(8'h41, 1'b1);
    drive_bit(1'b1, 50);

    // Short glitch: start is rejected at mid-bit
    drive_bit(1'b0, 40);
    drive_bit(1'b1, 10);
    #1 chk("glitch_busy_high", busy, 1'b1);
    drive_bit(1'b1, 39);
    #1 chk("glitch_busy_low", busy, 1'b0);
    drive_bit(1'b1, 100);

    // Stop bit low followed by a long break
    send_frame(8'h55, 1'b0);
    drive_bit(1'b0, 2000);
    #1 chk("break_busy_high", busy, 1'b1);
    chk("break_data_hold", data_out, 8'h41);
    drive_bit(1'b1, 100);
    #1 chk("break_busy_low", busy, 1'b0);

    // Back-to-back response strings
    send_string("OK\r\n");
    drive_bit(1'b1, 100);
    send_string("OOK\r\nERROR\r\n");
    drive_bit(1'b1, 100);

    // Reset in the middle of the data bits of 0x33, released with rx low
    drive_bit(1'b0, BIT_CLKS);
    drive_bit(1'b1, BIT_CLKS);
    drive_bit(1'b1, BIT_CLKS);
    drive_bit(1'b0, 80);
    #1 chk("pre_reset_busy", busy, 1'b1);
    rst_n = 1'b0;
    #1 chk_all_zero("midframe_reset");
    hist.delete();
    last_good = 8'h00;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (500) @(posedge clk);
    #1 chk("held_low_no_start", busy, 1'b0);
    drive_bit(1'b1, 300);
    send_frame(8'h33, 1'b1);
    drive_bit(1'b1, 50);

    // Randomized mix of bytes and response strings
    for (int it = 0; it < 3; it++) begin
      sel = $urandom_range(0, 3);
      case (sel)
        0: rb = CH_PICK(8'h4F);
        1: rb = CH_PICK(8'h45);
        default: rb = 8'($urandom_range(0, 255));
      endcase
      send_frame(rb, 1'b1);
      gap = $urandom_range(0, 30);
      if (gap > 0) drive_bit(1'b1, gap);
      sel = $urandom_range(0, 2);
      if (sel == 1) send_string("OK\r\n");
      else if (sel == 2) send_string("ERROR\r\n");
      gap = $urandom_range(0, 30);
      if (gap > 0) drive_bit(1'b1, gap);
    end

    drive_bit(1'b1, 300);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  function automatic logic [7:0] CH_PICK(input logic [7:0] c);
    return c;
  endfunction

endmodule
